// File: rtl/prog_ctr_stack_if.sv
// Fetch-stage control bus between the decoder and the program counter.
// The master (decoder side) drives the control requests; the slave
// (program counter) drives the PC and the run-status flags.
interface prog_ctr_stack_if #(
   parameter int L = 10,
   parameter int D = 4
);
   localparam int DW = $clog2(D + 1);

   logic          Start;
   logic          Halt;
   logic          BranchAbs;
   logic          BranchRel;
   logic          CondEn;
   logic          Zero;
   logic          Call;
   logic          Ret;
   logic [L-1:0]  Target;
   logic [L-1:0]  ProgCtr;
   logic          Running;
   logic          Done;
   logic          Fault;
   logic [DW-1:0] Depth;

   modport master (
      output Start, Halt, BranchAbs, BranchRel, CondEn, Zero, Call, Ret, Target,
      input  ProgCtr, Running, Done, Fault, Depth
   );

   modport slave (
      input  Start, Halt, BranchAbs, BranchRel, CondEn, Zero, Call, Ret, Target,
      output ProgCtr, Running, Done, Fault, Depth
   );
endinterface

// File: rtl/prog_ctr_stack.sv
// Program counter with conditional absolute/relative branches, a hardware
// return-address stack for call/return, and an IDLE/RUN/DONE/FAULT run
// controller. ProgCtr drives the instruction ROM address directly.
module prog_ctr_stack #(
   parameter int           L         = 10,
   parameter int           D         = 4,
   parameter logic [L-1:0] RESET_VEC = '0
) (
   input logic              Clk,
   input logic              Reset,
   prog_ctr_stack_if.slave  bus
);
   localparam int DW = $clog2(D + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   logic [1:0]    state_reg, state_next;
   logic [L-1:0]  pc_reg, pc_next;
   logic [DW-1:0] depth_reg, depth_next;
   logic [L-1:0]  stack_reg [D];
   logic [L-1:0]  stack_top;
   logic [L-1:0]  pc_plus1;
   logic          push;
   logic          taken;

   assign pc_plus1 = pc_reg + L'(1);
   assign taken    = ~bus.CondEn | bus.Zero;

   // Select the newest valid return address (entry Depth-1).
   always_comb begin
      stack_top = '0;
      for (int i = 0; i < D; i++) begin
         if (depth_reg == DW'(i + 1)) stack_top = stack_reg[i];
      end
   end

   // Run controller and next-PC selection; in RUN exactly one action
   // fires per edge, highest priority first.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      depth_next = depth_reg;
      push       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (bus.Start) state_next = S_RUN;
         end
         S_RUN: begin
            if (bus.Halt) begin
               state_next = S_DONE;
            end else if (bus.Ret) begin
               if (depth_reg == '0) begin
                  state_next = S_FAULT;
               end else begin
                  pc_next    = stack_top;
                  depth_next = depth_reg - DW'(1);
               end
            end else if (bus.Call) begin
               if (depth_reg == DW'(D)) begin
                  state_next = S_FAULT;
               end else begin
                  push       = 1'b1;
                  depth_next = depth_reg + DW'(1);
                  pc_next    = bus.Target;
               end
            end else if (bus.BranchAbs && taken) begin
               pc_next = bus.Target;
            end else if (bus.BranchRel && taken) begin
               // Same-width add is the sign-extended add modulo 2^L.
               pc_next = pc_reg + bus.Target;
            end else begin
               pc_next = pc_plus1;
            end
         end
         S_DONE: begin
            if (bus.Start) begin
               state_next = S_RUN;
               pc_next    = RESET_VEC;
               depth_next = '0;
            end
         end
         default: ;  // FAULT is sticky until Reset
      endcase
   end

   // Control state registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg <= S_IDLE;
         pc_reg    <= RESET_VEC;
         depth_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         depth_reg <= depth_next;
      end
   end

   // Return-address stack; contents need no reset since Depth gates validity.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < D; i++) begin
         if (push && depth_reg == DW'(i)) stack_reg[i] <= pc_plus1;
      end
   end

   assign bus.ProgCtr = pc_reg;
   assign bus.Depth   = depth_reg;
   assign bus.Running = (state_reg == S_RUN);
   assign bus.Done    = (state_reg == S_DONE);
   assign bus.Fault   = (state_reg == S_FAULT);
endmodule

// File: tb/tb_prog_ctr_stack.sv
// Directed bench for prog_ctr_stack (L=10, D=4, RESET_VEC=0).
module tb_prog_ctr_stack;
   logic Clk;
   logic Reset;
   int   checks;
   int   fails;

   prog_ctr_stack_if #(.L(10), .D(4)) bus ();

   prog_ctr_stack #(.L(10), .D(4), .RESET_VEC(10'd0)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic clear_ctl();
      bus.Start = 0; bus.Halt = 0; bus.BranchAbs = 0; bus.BranchRel = 0;
      bus.CondEn = 0; bus.Zero = 0; bus.Call = 0; bus.Ret = 0; bus.Target = '0;
   endtask

   // One clock edge, then sample 1 time unit later and release all controls.
   task automatic step(input string tag);
      @(posedge Clk);
      #1;
      $display("%s: pc=%0d depth=%0d run=%b done=%b fault=%b", tag,
               bus.ProgCtr, bus.Depth, bus.Running, bus.Done, bus.Fault);
      clear_ctl();
      Reset = 0;
   endtask

   task automatic test_reset();
      Reset = 1;
      step("reset");
      checks++; if (bus.ProgCtr !== 10'd0) begin fails++; $display("FAIL reset_pc: got %0d want 0", bus.ProgCtr); end
      checks++; if (bus.Depth !== 3'd0) begin fails++; $display("FAIL reset_depth: got %0d want 0", bus.Depth); end
      checks++; if ({bus.Running, bus.Done, bus.Fault} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {bus.Running, bus.Done, bus.Fault}); end
      // IDLE ignores everything except Start
      bus.BranchAbs = 1; bus.Target = 10'd77; bus.Call = 1;
      step("idle_ignore");
      checks++; if (bus.ProgCtr !== 10'd0 || bus.Running !== 1'b0 || bus.Depth !== 3'd0) begin fails++; $display("FAIL idle_ignore: got pc=%0d run=%b depth=%0d want 0/0/0", bus.ProgCtr, bus.Running, bus.Depth); end
   endtask

   task automatic test_start();
      bus.Start = 1;
      step("start");
      checks++; if (bus.ProgCtr !== 10'd0 || bus.Running !== 1'b1) begin fails++; $display("FAIL start_edge: got pc=%0d run=%b want 0/1", bus.ProgCtr, bus.Running); end
      for (int i = 1; i <= 3; i++) begin
         step("free_run");
         checks++; if (bus.ProgCtr !== 10'(i)) begin fails++; $display("FAIL free_run: got %0d want %0d", bus.ProgCtr, i); end
      end
   endtask

   task automatic test_branches();
      step("inc"); step("inc");  // PC 3 -> 5
      checks++; if (bus.ProgCtr !== 10'd5) begin fails++; $display("FAIL reach5: got %0d want 5", bus.ProgCtr); end
      bus.BranchRel = 1; bus.Target = 10'h3FE; bus.CondEn = 1; bus.Zero = 0;
      step("rel_untaken");
      checks++; if (bus.ProgCtr !== 10'd6) begin fails++; $display("FAIL rel_untaken: got %0d want 6", bus.ProgCtr); end
      bus.BranchRel = 1; bus.Target = 10'h3FE; bus.CondEn = 1; bus.Zero = 1;
      step("rel_taken");
      checks++; if (bus.ProgCtr !== 10'd4) begin fails++; $display("FAIL rel_taken: got %0d want 4", bus.ProgCtr); end
      bus.BranchAbs = 1; bus.Target = 10'd20; bus.CondEn = 1; bus.Zero = 0;
      step("abs_untaken");
      checks++; if (bus.ProgCtr !== 10'd5) begin fails++; $display("FAIL abs_untaken: got %0d want 5", bus.ProgCtr); end
      bus.BranchAbs = 1; bus.Target = 10'd20; bus.CondEn = 0;
      step("abs_uncond");
      checks++; if (bus.ProgCtr !== 10'd20) begin fails++; $display("FAIL abs_uncond: got %0d want 20", bus.ProgCtr); end
   endtask

   task automatic test_wrap();
      bus.BranchAbs = 1; bus.Target = 10'd1020;
      step("to1020");
      for (int i = 1021; i <= 1024; i++) begin
         step("wrap_run");
         checks++; if (bus.ProgCtr !== 10'(i % 1024) || bus.Fault !== 1'b0) begin fails++; $display("FAIL wrap_run: got pc=%0d fault=%b want %0d/0", bus.ProgCtr, bus.Fault, i % 1024); end
      end
      step("inc"); step("inc");  // PC 0 -> 2
      bus.BranchRel = 1; bus.Target = 10'h3FB;  // -5
      step("rel_wrap");
      checks++; if (bus.ProgCtr !== 10'd1021) begin fails++; $display("FAIL rel_wrap: got %0d want 1021", bus.ProgCtr); end
   endtask

   task automatic test_calls();
      bus.BranchAbs = 1; bus.Target = 10'd7;
      step("to7");
      bus.Call = 1; bus.Target = 10'd100; bus.BranchAbs = 1;  // BranchAbs discarded
      step("call100");
      checks++; if (bus.ProgCtr !== 10'd100 || bus.Depth !== 3'd1) begin fails++; $display("FAIL call100: got pc=%0d depth=%0d want 100/1", bus.ProgCtr, bus.Depth); end
      bus.Call = 1; bus.Target = 10'd200;
      step("call200");
      checks++; if (bus.ProgCtr !== 10'd200 || bus.Depth !== 3'd2) begin fails++; $display("FAIL call200: got pc=%0d depth=%0d want 200/2", bus.ProgCtr, bus.Depth); end
      bus.Ret = 1; bus.Call = 1; bus.Target = 10'd300;  // Ret wins over Call
      step("ret1");
      checks++; if (bus.ProgCtr !== 10'd101 || bus.Depth !== 3'd1) begin fails++; $display("FAIL ret1: got pc=%0d depth=%0d want 101/1", bus.ProgCtr, bus.Depth); end
      bus.Ret = 1;
      step("ret2");
      checks++; if (bus.ProgCtr !== 10'd8 || bus.Depth !== 3'd0) begin fails++; $display("FAIL ret2: got pc=%0d depth=%0d want 8/0", bus.ProgCtr, bus.Depth); end
   endtask

   task automatic test_call_overflow();
      for (int i = 0; i < 5; i++) begin
         bus.Call = 1; bus.Target = 10'(300 + 10 * i);
         step("call_ovf");
      end
      checks++; if (bus.Fault !== 1'b1 || bus.Running !== 1'b0) begin fails++; $display("FAIL ovf_fault: got fault=%b run=%b want 1/0", bus.Fault, bus.Running); end
      checks++; if (bus.ProgCtr !== 10'd330 || bus.Depth !== 3'd4) begin fails++; $display("FAIL ovf_frozen: got pc=%0d depth=%0d want 330/4", bus.ProgCtr, bus.Depth); end
      bus.Start = 1; bus.Ret = 1;
      step("fault_start");
      checks++; if (bus.Fault !== 1'b1 || bus.ProgCtr !== 10'd330 || bus.Depth !== 3'd4) begin fails++; $display("FAIL fault_sticky: got fault=%b pc=%0d depth=%0d want 1/330/4", bus.Fault, bus.ProgCtr, bus.Depth); end
      Reset = 1;
      step("fault_reset");
      checks++; if (bus.ProgCtr !== 10'd0 || bus.Depth !== 3'd0 || {bus.Running, bus.Done, bus.Fault} !== 3'b000) begin fails++; $display("FAIL fault_reset: got pc=%0d depth=%0d flags=%b want 0/0/000", bus.ProgCtr, bus.Depth, {bus.Running, bus.Done, bus.Fault}); end
   endtask

   task automatic test_ret_underflow();
      bus.Start = 1;
      step("start");
      step("inc"); step("inc");  // PC 2
      bus.Ret = 1;
      step("ret_empty");
      checks++; if (bus.Fault !== 1'b1 || bus.ProgCtr !== 10'd2 || bus.Depth !== 3'd0) begin fails++; $display("FAIL ret_empty: got fault=%b pc=%0d depth=%0d want 1/2/0", bus.Fault, bus.ProgCtr, bus.Depth); end
      Reset = 1;
      step("reset");
   endtask

   task automatic test_back_to_back();
      bus.Start = 1;
      step("start");
      bus.Call = 1; bus.Target = 10'd12;
      step("call12");
      bus.Halt = 1; bus.Call = 1; bus.Target = 10'd90;
      step("halt_call");
      checks++; if (bus.Done !== 1'b1 || bus.Running !== 1'b0 || bus.ProgCtr !== 10'd12 || bus.Depth !== 3'd1) begin fails++; $display("FAIL halt_call: got done=%b run=%b pc=%0d depth=%0d want 1/0/12/1", bus.Done, bus.Running, bus.ProgCtr, bus.Depth); end
      bus.BranchAbs = 1; bus.Target = 10'd55;
      step("done_hold");
      checks++; if (bus.Done !== 1'b1 || bus.ProgCtr !== 10'd12) begin fails++; $display("FAIL done_hold: got done=%b pc=%0d want 1/12", bus.Done, bus.ProgCtr); end
      bus.Start = 1;
      step("relaunch");
      checks++; if (bus.Running !== 1'b1 || bus.ProgCtr !== 10'd0 || bus.Depth !== 3'd0) begin fails++; $display("FAIL relaunch: got run=%b pc=%0d depth=%0d want 1/0/0", bus.Running, bus.ProgCtr, bus.Depth); end
      bus.BranchAbs = 1; bus.Target = 10'd40;
      step("to40");
      Reset = 1; bus.Call = 1; bus.Target = 10'd99;
      step("mid_reset");
      checks++; if (bus.ProgCtr !== 10'd0 || bus.Running !== 1'b0 || bus.Depth !== 3'd0) begin fails++; $display("FAIL mid_reset: got pc=%0d run=%b depth=%0d want 0/0/0", bus.ProgCtr, bus.Running, bus.Depth); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      Reset  = 1;
      clear_ctl();
      test_reset();
      test_start();
      test_branches();
      test_wrap();
      test_calls();
      test_call_overflow();
      test_ret_underflow();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
